matmul_addr_gen: RTL and testbench
==================================

MATMUL_ADDR_GEN -- requirements
Module: matmul_addr_gen

Interface
REQ-001 Parameter addr_width, default 16, width of all address ports and base registers.
REQ-002 Parameter dim_width, default 8, width of the dimension inputs and loop indices.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 start  in  1  one-cycle job request, honoured only in IDLE.
REQ-006 dim_m, dim_n, dim_k  in  dim_width each  matrix sizes: A is MxK, B is KxN, C is MxN.
REQ-007 base_a, base_b, base_c  in  addr_width each  row-major base addresses of A, B and C.
REQ-008 stall  in  1  freezes the sequence when high.
REQ-009 addr_a, addr_b  out  addr_width  operand addresses; meaningful when mac_valid is high.
REQ-010 mac_valid  out  1  one multiply-accumulate beat issued this cycle.
REQ-011 acc_clr  out  1  high with the k=0 beat; the accumulator register loads instead of adding.
REQ-012 addr_c  out  addr_width  result address; meaningful when c_write_en is high.
REQ-013 c_write_en  out  1  write strobe for the result register/memory.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, RUN, WRITE and FIN.
REQ-017 In IDLE, start=1 SHALL latch all dims and bases, clear i, j and k, and enter RUN; if any dim is 0, the FSM SHALL enter FIN instead.
REQ-018 start SHALL be ignored while busy=1, and the latched dims and bases SHALL stay unchanged.
REQ-019 In RUN with stall=0: mac_valid=1, and acc_clr=(k==0).
REQ-020 The operand addresses SHALL be addr_a=base_a+i*K+k and addr_b=base_b+k*N+j, computed with running pointers (no multipliers): k step adds 1 to addr_a and N to addr_b.
REQ-021 In RUN with stall=1: mac_valid=0, acc_clr=0, and all counters, pointers and the state SHALL be held.
REQ-022 A RUN beat with k==K-1 SHALL move the FSM to WRITE on the next cycle.
REQ-023 WRITE SHALL last exactly one cycle regardless of stall, with c_write_en=1 and addr_c=base_c+i*N+j; addr_c SHALL increment by 1 after each write.
REQ-024 Leaving WRITE when j<N-1: j+=1, k=0, addr_a returns to the row start, addr_b=base_b+j+1, and the FSM returns to RUN.
REQ-025 Leaving WRITE when j==N-1 and i<M-1: i+=1, j=0, k=0, the row start advances by K, addr_b=base_b, and the FSM returns to RUN.
REQ-026 Leaving WRITE when i==M-1 and j==N-1: the FSM SHALL enter FIN.
REQ-027 FIN SHALL last one cycle with done=1, then return to IDLE; a start in that cycle is ignored.
REQ-028 The total cycle count for a job with no stalls SHALL be M*N*(K+1)+1 from the first RUN cycle through FIN.
REQ-029 All address arithmetic SHALL wrap modulo 2^addr_width with no error flag.
REQ-030 mac_valid, acc_clr, c_write_en and done SHALL be registered outputs, and SHALL be 0 in every state where they are not defined above.

Reset
REQ-031 rst=1 SHALL force IDLE in the same clock edge, with every output 0 and every counter and pointer 0, including when asserted mid-RUN or mid-WRITE.
REQ-032 When rst=1 and start=1 occur in the same cycle, rst SHALL win.

Structure
REQ-033 A shared package matmul_pkg SHALL hold the state enum and the default addr_width and dim_width constants.
REQ-034 A single sub-module loop_counter (dim_width wide, with enable, clear and limit inputs and a terminal-count output) SHALL be instantiated three times, for i, j and k.

Verification
REQ-035 M=N=K=2, base_a=0x0010, base_b=0x0020, base_c=0x0030, no stall -> addr_a 10,11,10,11,12,13,12,13; addr_b 20,22,21,23,20,22,21,23; addr_c 30,31,32,33; done on cycle 13.
REQ-036 The same job with stall=1 on the 3rd RUN cycle for 2 cycles -> identical address sequence, mac_valid low for those 2 cycles, done 2 cycles later.
REQ-037 dim_k=0 with start=1 -> no mac_valid and no c_write_en, done one cycle after start, busy high for exactly one cycle.
REQ-038 rst=1 during the 2nd WRITE -> next cycle all outputs 0 and busy=0; a new start then replays the full sequence from addr_a=base_a.
REQ-039 base_a=0xFFFF, M=N=1, K=2 -> addr_a 0xFFFF then 0x0000 (wrap), one write to base_c.
REQ-040 start pulsed mid-job with different dims -> ignored; the original sequence completes unchanged.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and default widths for the matrix-multiply address generator.
package matmul_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DIM_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WRITE,
        FIN
    } state_t;

endpackage

// File: rtl/loop_counter.sv
// Wrapping loop index: counts 0..limit, tc flags the last value, wraps to 0 on an enabled step at tc.
module loop_counter
    import matmul_pkg::*;
#(
    parameter int dim_width = DEF_DIM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [dim_width-1:0] limit,
    output logic                 tc
);

    logic [dim_width-1:0] count;

    assign tc = (count == limit);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + dim_width'(1);
        end
    end

endmodule

// File: rtl/matmul_addr_gen.sv
// Operand/result address sequencer for C = A x B, walking i (rows), j (cols), k (inner) with
// running pointers; stall is sampled at the clock edge and suppresses the following beat.
module matmul_addr_gen
    import matmul_pkg::*;
#(
    parameter int addr_width = DEF_ADDR_WIDTH,
    parameter int dim_width  = DEF_DIM_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [dim_width-1:0]  dim_m,
    input  logic [dim_width-1:0]  dim_n,
    input  logic [dim_width-1:0]  dim_k,
    input  logic [addr_width-1:0] base_a,
    input  logic [addr_width-1:0] base_b,
    input  logic [addr_width-1:0] base_c,
    input  logic                  stall,
    output logic [addr_width-1:0] addr_a,
    output logic [addr_width-1:0] addr_b,
    output logic                  mac_valid,
    output logic                  acc_clr,
    output logic [addr_width-1:0] addr_c,
    output logic                  c_write_en,
    output logic                  busy,
    output logic                  done
);

    state_t                state;
    logic [dim_width-1:0]  m_q, n_q, k_q;
    logic [addr_width-1:0] base_b_q;
    logic [addr_width-1:0] row_a;
    logic [addr_width-1:0] col_b;
    logic                  k_first;
    logic                  accept, any_zero;
    logic                  i_tc, j_tc, k_tc;

    assign accept   = (state == IDLE) && start;
    assign any_zero = (dim_m == '0) || (dim_n == '0) || (dim_k == '0);
    assign busy     = (state != IDLE);

    loop_counter #(.dim_width(dim_width)) u_i_cnt (
        .clk(clk), .rst(rst), .clr(accept),
        .en((state == WRITE) && j_tc),
        .limit(m_q - dim_width'(1)), .tc(i_tc)
    );

    loop_counter #(.dim_width(dim_width)) u_j_cnt (
        .clk(clk), .rst(rst), .clr(accept),
        .en(state == WRITE),
        .limit(n_q - dim_width'(1)), .tc(j_tc)
    );

    // k advances only on an issued beat; a stalled RUN cycle leaves it untouched.
    loop_counter #(.dim_width(dim_width)) u_k_cnt (
        .clk(clk), .rst(rst), .clr(accept),
        .en((state == RUN) && mac_valid),
        .limit(k_q - dim_width'(1)), .tc(k_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mac_valid  <= 1'b0;
            acc_clr    <= 1'b0;
            c_write_en <= 1'b0;
            done       <= 1'b0;
            k_first    <= 1'b0;
            addr_a     <= '0;
            addr_b     <= '0;
            addr_c     <= '0;
            row_a      <= '0;
            col_b      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mac_valid  <= 1'b0;
                    acc_clr    <= 1'b0;
                    c_write_en <= 1'b0;
                    done       <= 1'b0;
                    if (start) begin
                        m_q      <= dim_m;
                        n_q      <= dim_n;
                        k_q      <= dim_k;
                        base_b_q <= base_b;
                        addr_a   <= base_a;
                        row_a    <= base_a;
                        addr_b   <= base_b;
                        col_b    <= base_b;
                        addr_c   <= base_c;
                        if (any_zero) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state     <= RUN;
                            k_first   <= 1'b1;
                            mac_valid <= !stall;
                            acc_clr   <= !stall;
                        end
                    end
                end
                RUN: begin
                    if (mac_valid) begin
                        if (k_tc) begin
                            state      <= WRITE;
                            mac_valid  <= 1'b0;
                            acc_clr    <= 1'b0;
                            c_write_en <= 1'b1;
                        end else begin
                            addr_a    <= addr_a + addr_width'(1);
                            addr_b    <= addr_b + addr_width'(n_q);
                            k_first   <= 1'b0;
                            mac_valid <= !stall;
                            acc_clr   <= 1'b0;
                        end
                    end else begin
                        mac_valid <= !stall;
                        acc_clr   <= !stall && k_first;
                    end
                end
                WRITE: begin
                    c_write_en <= 1'b0;
                    addr_c     <= addr_c + addr_width'(1);
                    if (!j_tc) begin
                        state     <= RUN;
                        addr_a    <= row_a;
                        addr_b    <= col_b + addr_width'(1);
                        col_b     <= col_b + addr_width'(1);
                        k_first   <= 1'b1;
                        mac_valid <= !stall;
                        acc_clr   <= !stall;
                    end else if (!i_tc) begin
                        state     <= RUN;
                        row_a     <= row_a + addr_width'(k_q);
                        addr_a    <= row_a + addr_width'(k_q);
                        addr_b    <= base_b_q;
                        col_b     <= base_b_q;
                        k_first   <= 1'b1;
                        mac_valid <= !stall;
                        acc_clr   <= !stall;
                    end else begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_addr_gen.sv
// Directed bench for matmul_addr_gen: hand-computed address sequences, stalls, resets and wrap.
module tb_matmul_addr_gen;

    logic        clk = 1'b0;
    logic        rst, start, stall;
    logic [7:0]  dim_m, dim_n, dim_k;
    logic [15:0] base_a, base_b, base_c;
    logic [15:0] addr_a, addr_b, addr_c;
    logic        mac_valid, acc_clr, c_write_en, busy, done;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] qc[$];
    logic        qclr[$];
    logic        mv_at[64];
    int          done_cyc;

    // Expected 2x2x2 job with bases 0x10/0x20/0x30.
    logic [15:0] exp_a[8] = '{16'h10, 16'h11, 16'h10, 16'h11, 16'h12, 16'h13, 16'h12, 16'h13};
    logic [15:0] exp_b[8] = '{16'h20, 16'h22, 16'h21, 16'h23, 16'h20, 16'h22, 16'h21, 16'h23};
    logic [15:0] exp_c[4] = '{16'h30, 16'h31, 16'h32, 16'h33};

    always #5 clk = ~clk;

    matmul_addr_gen #(.addr_width(16), .dim_width(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dim_m(dim_m), .dim_n(dim_n), .dim_k(dim_k),
        .base_a(base_a), .base_b(base_b), .base_c(base_c),
        .stall(stall),
        .addr_a(addr_a), .addr_b(addr_b), .mac_valid(mac_valid), .acc_clr(acc_clr),
        .addr_c(addr_c), .c_write_en(c_write_en), .busy(busy), .done(done)
    );

    task automatic set_job(input logic [7:0] m, input logic [7:0] n, input logic [7:0] k,
                           input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] bc);
        dim_m = m; dim_n = n; dim_k = k;
        base_a = ba; base_b = bb; base_c = bc;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Records one job starting in cycle 1; stall is driven so that mac_valid is suppressed in
    // cycles stall_from..stall_from+stall_len-1; poke_cyc pulses a stray start with new job values.
    task automatic capture(input int limit, input int stall_from, input int stall_len, input int poke_cyc);
        qa.delete(); qb.delete(); qc.delete(); qclr.delete();
        done_cyc = -1;
        for (int c = 0; c < 64; c++) mv_at[c] = 1'b0;
        for (int cyc = 1; cyc <= limit; cyc++) begin
            if (mac_valid) begin
                qa.push_back(addr_a);
                qb.push_back(addr_b);
                qclr.push_back(acc_clr);
            end
            if (c_write_en) qc.push_back(addr_c);
            if (cyc < 64) mv_at[cyc] = mac_valid;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            stall = (cyc + 1 >= stall_from) && (cyc + 1 < stall_from + stall_len);
            if (cyc == poke_cyc) begin
                start = 1'b1;
                set_job(8'd3, 8'd3, 8'd3, 16'h0500, 16'h0600, 16'h0700);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        stall = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; stall = 1'b0;
        set_job(8'd2, 8'd2, 8'd2, 16'h10, 16'h20, 16'h30);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        vectors++;
        if ({addr_a, addr_b, addr_c} !== 48'h0) begin
            miscompares++;
            $display("FAIL reset_addr got %h %h %h want 0 0 0", addr_a, addr_b, addr_c);
        end
        vectors++;
        if ({mac_valid, acc_clr, c_write_en, done, busy} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b want 00000", {mac_valid, acc_clr, c_write_en, done, busy});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_busy got %b want 0", busy);
        end
    endtask

    task automatic test_basic();
        set_job(8'd2, 8'd2, 8'd2, 16'h10, 16'h20, 16'h30);
        do_start();
        capture(40, 0, 0, 0);
        vectors++;
        if (qa.size() != 8) begin
            miscompares++;
            $display("FAIL basic_beats got %0d want 8", qa.size());
        end
        for (int i = 0; i < 8 && i < qa.size(); i++) begin
            vectors++;
            if (qa[i] !== exp_a[i] || qb[i] !== exp_b[i]) begin
                miscompares++;
                $display("FAIL basic_ab[%0d] got %h/%h want %h/%h", i, qa[i], qb[i], exp_a[i], exp_b[i]);
            end
            vectors++;
            if (qclr[i] !== ((i % 2) == 0)) begin
                miscompares++;
                $display("FAIL basic_acc_clr[%0d] got %b want %b", i, qclr[i], (i % 2) == 0);
            end
        end
        vectors++;
        if (qc.size() != 4) begin
            miscompares++;
            $display("FAIL basic_writes got %0d want 4", qc.size());
        end
        for (int i = 0; i < 4 && i < qc.size(); i++) begin
            vectors++;
            if (qc[i] !== exp_c[i]) begin
                miscompares++;
                $display("FAIL basic_addr_c[%0d] got %h want %h", i, qc[i], exp_c[i]);
            end
        end
        vectors++;
        if (done_cyc != 13) begin
            miscompares++;
            $display("FAIL basic_done_cycle got %0d want 13", done_cyc);
        end
        @(posedge clk); #1;
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL basic_after_fin got %b want 00", {busy, done});
        end
    endtask

    task automatic test_stall();
        set_job(8'd2, 8'd2, 8'd2, 16'h10, 16'h20, 16'h30);
        do_start();
        capture(40, 4, 2, 0);
        vectors++;
        if (qa.size() != 8 || qc.size() != 4) begin
            miscompares++;
            $display("FAIL stall_counts got %0d/%0d want 8/4", qa.size(), qc.size());
        end
        for (int i = 0; i < 8 && i < qa.size(); i++) begin
            vectors++;
            if (qa[i] !== exp_a[i] || qb[i] !== exp_b[i] || qclr[i] !== ((i % 2) == 0)) begin
                miscompares++;
                $display("FAIL stall_beat[%0d] got %h/%h/%b want %h/%h/%b", i, qa[i], qb[i], qclr[i],
                         exp_a[i], exp_b[i], (i % 2) == 0);
            end
        end
        for (int i = 0; i < 4 && i < qc.size(); i++) begin
            vectors++;
            if (qc[i] !== exp_c[i]) begin
                miscompares++;
                $display("FAIL stall_addr_c[%0d] got %h want %h", i, qc[i], exp_c[i]);
            end
        end
        vectors++;
        if ({mv_at[4], mv_at[5], mv_at[6]} !== 3'b001) begin
            miscompares++;
            $display("FAIL stall_mac_valid got %b want 001", {mv_at[4], mv_at[5], mv_at[6]});
        end
        vectors++;
        if (done_cyc != 15) begin
            miscompares++;
            $display("FAIL stall_done_cycle got %0d want 15", done_cyc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_dim();
        set_job(8'd2, 8'd2, 8'd0, 16'h10, 16'h20, 16'h30);
        do_start();
        vectors++;
        if ({done, busy, mac_valid, c_write_en} !== 4'b1100) begin
            miscompares++;
            $display("FAIL zero_fin got %b want 1100", {done, busy, mac_valid, c_write_en});
        end
        // A start during FIN must not launch a job.
        dim_k = 8'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if ({done, busy, mac_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL zero_after got %b want 000", {done, busy, mac_valid});
        end
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL fin_start_ignored busy got %b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int writes = 0;
        set_job(8'd2, 8'd2, 8'd2, 16'h10, 16'h20, 16'h30);
        do_start();
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (c_write_en) writes++;
            if (writes == 2) break;
            @(posedge clk); #1;
        end
        vectors++;
        if (writes != 2) begin
            miscompares++;
            $display("FAIL rstmid_second_write got %0d writes want 2", writes);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if ({addr_a, addr_b, addr_c, mac_valid, acc_clr, c_write_en, done, busy} !== 53'h0) begin
            miscompares++;
            $display("FAIL rstmid_outputs got %h %h %h %b want all 0", addr_a, addr_b, addr_c,
                     {mac_valid, acc_clr, c_write_en, done, busy});
        end
        do_start();
        capture(40, 0, 0, 0);
        vectors++;
        if (qa.size() != 8 || qc.size() != 4 || done_cyc != 13) begin
            miscompares++;
            $display("FAIL rstmid_replay got %0d/%0d/%0d want 8/4/13", qa.size(), qc.size(), done_cyc);
        end
        for (int i = 0; i < 8 && i < qa.size(); i++) begin
            vectors++;
            if (qa[i] !== exp_a[i] || qb[i] !== exp_b[i]) begin
                miscompares++;
                $display("FAIL rstmid_ab[%0d] got %h/%h want %h/%h", i, qa[i], qb[i], exp_a[i], exp_b[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        set_job(8'd1, 8'd1, 8'd2, 16'hFFFF, 16'h0100, 16'h0200);
        do_start();
        capture(20, 0, 0, 0);
        vectors++;
        if (qa.size() != 2 || qc.size() != 1) begin
            miscompares++;
            $display("FAIL wrap_counts got %0d/%0d want 2/1", qa.size(), qc.size());
        end
        if (qa.size() == 2) begin
            vectors++;
            if (qa[0] !== 16'hFFFF || qa[1] !== 16'h0000) begin
                miscompares++;
                $display("FAIL wrap_addr_a got %h,%h want ffff,0000", qa[0], qa[1]);
            end
            vectors++;
            if (qb[0] !== 16'h0100 || qb[1] !== 16'h0101) begin
                miscompares++;
                $display("FAIL wrap_addr_b got %h,%h want 0100,0101", qb[0], qb[1]);
            end
        end
        if (qc.size() == 1) begin
            vectors++;
            if (qc[0] !== 16'h0200) begin
                miscompares++;
                $display("FAIL wrap_addr_c got %h want 0200", qc[0]);
            end
        end
        vectors++;
        if (done_cyc != 4) begin
            miscompares++;
            $display("FAIL wrap_done_cycle got %0d want 4", done_cyc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start();
        set_job(8'd2, 8'd2, 8'd2, 16'h10, 16'h20, 16'h30);
        do_start();
        capture(60, 0, 0, 5);
        vectors++;
        if (qa.size() != 8 || qc.size() != 4 || done_cyc != 13) begin
            miscompares++;
            $display("FAIL ignore_counts got %0d/%0d/%0d want 8/4/13", qa.size(), qc.size(), done_cyc);
        end
        for (int i = 0; i < 8 && i < qa.size(); i++) begin
            vectors++;
            if (qa[i] !== exp_a[i] || qb[i] !== exp_b[i]) begin
                miscompares++;
                $display("FAIL ignore_ab[%0d] got %h/%h want %h/%h", i, qa[i], qb[i], exp_a[i], exp_b[i]);
            end
        end
        for (int i = 0; i < 4 && i < qc.size(); i++) begin
            vectors++;
            if (qc[i] !== exp_c[i]) begin
                miscompares++;
                $display("FAIL ignore_addr_c[%0d] got %h want %h", i, qc[i], exp_c[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero_dim();
        test_reset_mid();
        test_wrap();
        test_ignore_start();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
